// File: rtl/pulse_to_level_pkg.sv
// Shared types for the pulse-to-level converter.
// State encodings and the minimum legal gap length.
package pulse_to_level_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    GAP    = 2'b10
  } state_e;

  localparam int MIN_GAP_CYCLES = 1;

  function automatic int gap_eff(input int g);
    return (g < MIN_GAP_CYCLES) ? MIN_GAP_CYCLES : g;
  endfunction

endpackage

// File: rtl/pulse_pend_cnt.sv
// Saturating up/down counter of queued request pulses.
// An increment at full scale is dropped and strobes ovf_stb.
module pulse_pend_cnt #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf_stb
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic inc_ok;
  logic dec_ok;

  // A full counter drops the new pulse even when a dequeue lands too.
  assign ovf_stb = inc && (cnt == MAX);
  assign inc_ok  = inc && !ovf_stb;
  assign dec_ok  = dec && (cnt != '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/pulse_to_level.sv
// Stretches request pulses into level windows with forced low gaps.
// Pulses during a window are queued and replayed back-to-back.
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int PEND_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PULSE_SIG,
  input  logic [LEN_W-1:0]  LVL_LEN,
  input  logic              CLR_OVF,
  output logic              LVL_SIG,
  output logic              BUSY,
  output logic [PEND_W-1:0] PEND_CNT,
  output logic              OVF
);

  localparam int GAP_N = gap_eff(GAP_CYCLES);
  localparam int GAP_W = $clog2(GAP_N) + 1;
  localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

  state_e             state_q;
  state_e             state_n;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_n;
  logic [CNT_W-1:0]   len_m1;
  logic               last_gap;
  logic               pend_nz;
  logic               inc;
  logic               dec;
  logic               ovf_stb;
  logic               lvl_d;
  logic               busy_d;
  logic               ovf_d;

  assign len_m1 = (LVL_LEN == '0) ? '0
                : CNT_W'(LVL_LEN - LEN_W'(1));

  assign last_gap = (state_q == GAP) && (cnt_q == '0);
  assign pend_nz  = (PEND_CNT != '0);

  // A pulse on an empty final gap cycle starts the next level directly.
  assign inc = PULSE_SIG && (state_q != IDLE)
            && !(last_gap && !pend_nz);
  assign dec = last_gap && pend_nz;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (PULSE_SIG) begin
          state_n = ACTIVE;
          cnt_n   = len_m1;
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          state_n = GAP;
          cnt_n   = CNT_W'(GAP_N - 1);
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else if (pend_nz || PULSE_SIG) begin
          state_n = ACTIVE;
          cnt_n   = len_m1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    lvl_d  = (state_n == ACTIVE);
    busy_d = (state_n != IDLE);
    ovf_d  = ovf_stb || (OVF && !CLR_OVF);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      LVL_SIG <= 1'b0;
      BUSY    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      LVL_SIG <= lvl_d;
      BUSY    <= busy_d;
      OVF     <= ovf_d;
    end
  end

  pulse_pend_cnt #(
    .W(PEND_W)
  ) u_pend (
    .CLK     (CLK),
    .RST     (RST),
    .inc     (inc),
    .dec     (dec),
    .cnt     (PEND_CNT),
    .ovf_stb (ovf_stb)
  );

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level.
// Vector table plus hand sequences for saturation and reset.
module tb_pulse_to_level;

  logic       CLK;
  logic       RST;
  logic       PULSE_SIG;
  logic [7:0] LVL_LEN;
  logic       CLR_OVF;
  logic       LVL_SIG;
  logic       BUSY;
  logic [1:0] PEND_CNT;
  logic       OVF;

  int vec_cnt;
  int err_cnt;

  pulse_to_level #(
    .LEN_W      (8),
    .PEND_W     (2),
    .GAP_CYCLES (1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PULSE_SIG (PULSE_SIG),
    .LVL_LEN   (LVL_LEN),
    .CLR_OVF   (CLR_OVF),
    .LVL_SIG   (LVL_SIG),
    .BUSY      (BUSY),
    .PEND_CNT  (PEND_CNT),
    .OVF       (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       pulse;
    logic [7:0] len;
    logic       clr;
    logic       lvl;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic [7:0] l, input logic c,
                     input logic lv, input logic b, input logic [1:0] pc,
                     input logic o);
    vec_t v;
    v.pulse = p; v.len = l; v.clr = c;
    v.lvl = lv; v.busy = b; v.pend = pc; v.ovf = o;
    tbl.push_back(v);
  endtask

  task automatic measure(input logic [7:0] len, input int budget,
                         output int highs, output int rises);
    logic prev;
    prev = 1'b0;
    highs = 0;
    rises = 0;
    PULSE_SIG = 1'b1;
    LVL_LEN = len;
    tick();
    PULSE_SIG = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (LVL_SIG && !prev) rises++;
      if (LVL_SIG) highs++;
      prev = LVL_SIG;
      tick();
    end
  endtask

  initial begin
    int   highs;
    int   rises;
    int   maxp;
    logic prev;

    vec_cnt = 0;
    err_cnt = 0;
    RST = 1'b0;
    PULSE_SIG = 1'b0;
    LVL_LEN = 8'd0;
    CLR_OVF = 1'b0;
    tick();
    tick();
    chk("rst lvl", int'(LVL_SIG), 0);
    chk("rst busy", int'(BUSY), 0);
    chk("rst pend", int'(PEND_CNT), 0);
    chk("rst ovf", int'(OVF), 0);
    RST = 1'b1;
    tick();

    // single level, len 3
    add(1, 3, 0, 1, 1, 0, 0);
    add(0, 3, 0, 1, 1, 0, 0);
    add(0, 3, 0, 1, 1, 0, 0);
    add(0, 3, 0, 0, 1, 0, 0);
    add(0, 3, 0, 0, 0, 0, 0);
    // three back-to-back pulses, len 2, len wiggled mid-level
    add(1, 2, 0, 1, 1, 0, 0);
    add(1, 9, 0, 1, 1, 1, 0);
    add(1, 2, 0, 0, 1, 2, 0);
    add(0, 2, 0, 1, 1, 1, 0);
    add(0, 9, 0, 1, 1, 1, 0);
    add(0, 2, 0, 0, 1, 1, 0);
    add(0, 2, 0, 1, 1, 0, 0);
    add(0, 2, 0, 1, 1, 0, 0);
    add(0, 2, 0, 0, 1, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0);
    // pulse on the last gap cycle with nothing queued
    add(1, 1, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      PULSE_SIG = tbl[i].pulse;
      LVL_LEN = tbl[i].len;
      CLR_OVF = tbl[i].clr;
      tick();
      chk($sformatf("v%0d lvl", i), int'(LVL_SIG), int'(tbl[i].lvl));
      chk($sformatf("v%0d busy", i), int'(BUSY), int'(tbl[i].busy));
      chk($sformatf("v%0d pend", i), int'(PEND_CNT), int'(tbl[i].pend));
      chk($sformatf("v%0d ovf", i), int'(OVF), int'(tbl[i].ovf));
    end
    PULSE_SIG = 1'b0;

    // length 0 acts as 1, length 255 stays high 255 cycles
    measure(8'd0, 10, highs, rises);
    chk("len0 highs", highs, 1);
    chk("len0 rises", rises, 1);
    measure(8'd255, 270, highs, rises);
    chk("len255 highs", highs, 255);
    chk("len255 rises", rises, 1);
    chk("len255 idle", int'(BUSY), 0);

    // six pulses, len 4: queue saturates at 3, two dropped
    prev = 1'b0;
    rises = 0;
    maxp = 0;
    LVL_LEN = 8'd4;
    for (int i = 0; i < 6; i++) begin
      PULSE_SIG = 1'b1;
      tick();
      if (LVL_SIG && !prev) rises++;
      prev = LVL_SIG;
      if (int'(PEND_CNT) > maxp) maxp = int'(PEND_CNT);
    end
    PULSE_SIG = 1'b0;
    chk("sat pend", int'(PEND_CNT), 2);
    chk("sat ovf", int'(OVF), 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (LVL_SIG && !prev) rises++;
      prev = LVL_SIG;
    end
    chk("sat max pend", maxp, 3);
    chk("sat rises", rises, 4);
    chk("sat drained", int'(PEND_CNT), 0);
    chk("sat idle", int'(BUSY), 0);
    chk("sat ovf sticky", int'(OVF), 1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    chk("clr ovf", int'(OVF), 0);

    // clear coinciding with a drop: set wins
    LVL_LEN = 8'd8;
    for (int i = 0; i < 5; i++) begin
      PULSE_SIG = 1'b1;
      CLR_OVF = (i == 4);
      tick();
      if (i == 3) chk("pre drop ovf", int'(OVF), 0);
    end
    PULSE_SIG = 1'b0;
    CLR_OVF = 1'b0;
    chk("clr+drop ovf", int'(OVF), 1);
    chk("clr+drop pend", int'(PEND_CNT), 3);
    chk("clr+drop lvl", int'(LVL_SIG), 1);

    // asynchronous reset mid-level
    #2;
    RST = 1'b0;
    #1;
    chk("arst lvl", int'(LVL_SIG), 0);
    chk("arst busy", int'(BUSY), 0);
    chk("arst pend", int'(PEND_CNT), 0);
    chk("arst ovf", int'(OVF), 0);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (LVL_SIG || BUSY) highs++;
    end
    chk("post rst quiet", highs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
